// File: rtl/core_pkg.sv
// Shared core definitions: FSM state encodings, core_state_o constants and
// the two instruction words the fetch controller recognises.
package core_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALT    = 2'd2,
        ST_TRAP    = 2'd3
    } state_e;

    localparam logic INSTRUCTION_FETCH   = 1'b0;
    localparam logic INSTRUCTION_EXECUTE = 1'b1;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/fetch_control_if.sv
// Instruction bus between the fetch controller (master) and the program ROM (slave).
// Handshake: none -- the read is combinational; the address is valid and the
// returned word is sampled only while core_state_o is INSTRUCTION_FETCH.
interface fetch_control_if;
    logic [31:0] program_pointer_o;
    logic [31:0] program_instr_i;

    modport master (output program_pointer_o, input program_instr_i);
    modport slave  (input program_pointer_o, output program_instr_i);
endinterface

// File: rtl/fetch_control.sv
// Two-phase instruction-fetch controller: owns PC, IR, retire counter and the
// FETCH/EXECUTE/HALT FSM. Optional misaligned-branch trap via `FETCH_TRAP_EN.
module fetch_control
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter logic [31:0] RETIRED_RESET = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    fetch_control_if.master         bus,
    output logic                    core_state_o,
    output logic [31:0]             instr_o,
    output logic                    instr_valid_o,
    input  logic                    stall_i,
    input  logic                    branch_taken_i,
    input  logic [31:0]             branch_target_i,
    output logic                    halted_o,
    output logic                    trap_o,
    output logic [31:0]             retired_o,
    output state_e                  state_dbg_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= INSTR_NOP;
            retired_q <= RETIRED_RESET;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.program_instr_i;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (!stall_i) begin
                    if (ir_q == INSTR_EBREAK) begin
                        // EBREAK retires but freezes the PC where it sits
                        state_d   = ST_HALT;
                        retired_d = retired_q + 32'd1;
                    end else begin
                        state_d   = ST_FETCH;
                        retired_d = retired_q + 32'd1;
                        pc_d      = branch_taken_i ? (branch_target_i & ~32'h3)
                                                   : pc_q + 32'd4;
`ifdef FETCH_TRAP_EN
                        if (branch_taken_i && (branch_target_i[1:0] != 2'b00)) begin
                            state_d   = ST_TRAP;
                            pc_d      = pc_q;
                            retired_d = retired_q;
                        end
`endif
                    end
                end
            end
`ifdef FETCH_TRAP_EN
            ST_TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = ST_FETCH;
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign bus.program_pointer_o = pc_q;
    assign instr_o               = ir_q;
    assign retired_o             = retired_q;
    assign state_dbg_o           = state_q;
    assign core_state_o          = (state_q == ST_FETCH) ? INSTRUCTION_FETCH
                                                         : INSTRUCTION_EXECUTE;
    assign instr_valid_o         = (state_q == ST_EXECUTE);
    assign halted_o              = (state_q == ST_HALT);
`ifdef FETCH_TRAP_EN
    assign trap_o                = (state_q == ST_TRAP);
`else
    assign trap_o                = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Directed scoreboard bench for fetch_control; a second instance with a
// near-full retire counter checks counter wraparound alongside.
module tb_fetch_control;

    localparam int W = 2 + 1 + 32 + 32 + 1 + 1 + 1 + 32 + 32;
    localparam logic [31:0] RET2_BASE = 32'hFFFF_FFFE;
    localparam logic [1:0] S_F = 2'd0, S_E = 2'd1, S_H = 2'd2, S_T = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br;
    logic [31:0] tgt;
    logic [31:0] rom_word;

    logic        core_state_a, valid_a, halted_a, trap_a;
    logic [31:0] instr_a, retired_a;
    logic [1:0]  state_a;
    logic        core_state_b, valid_b, halted_b, trap_b;
    logic [31:0] instr_b, retired_b;
    logic [1:0]  state_b;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    fetch_control_if bus_a ();
    fetch_control_if bus_b ();
    assign bus_a.program_instr_i = rom_word;
    assign bus_b.program_instr_i = rom_word;

    always #5 clk = ~clk;

    fetch_control u_dut (
        .clk_i(clk), .rst_i(rst), .bus(bus_a.master),
        .core_state_o(core_state_a), .instr_o(instr_a), .instr_valid_o(valid_a),
        .stall_i(stall), .branch_taken_i(br), .branch_target_i(tgt),
        .halted_o(halted_a), .trap_o(trap_a), .retired_o(retired_a),
        .state_dbg_o(state_a)
    );

    fetch_control #(.RETIRED_RESET(RET2_BASE)) u_wrap (
        .clk_i(clk), .rst_i(rst), .bus(bus_b.master),
        .core_state_o(core_state_b), .instr_o(instr_b), .instr_valid_o(valid_b),
        .stall_i(stall), .branch_taken_i(br), .branch_target_i(tgt),
        .halted_o(halted_b), .trap_o(trap_b), .retired_o(retired_b),
        .state_dbg_o(state_b)
    );

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic [31:0] word, input logic [1:0] e_st,
                       input logic [31:0] e_pc, input logic [31:0] e_ir,
                       input logic [31:0] e_ret, input string nm);
        rst = r; stall = s; br = b; tgt = t; rom_word = word;
        exp_q.push_back({e_st, (e_st != S_F), e_pc, e_ir, (e_st == S_E), (e_st == S_H),
                         (e_st == S_T), e_ret, e_ret + RET2_BASE});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, g;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            g = {state_a, core_state_a, bus_a.program_pointer_o, instr_a, valid_a, halted_a,
                 trap_a, retired_a, retired_b};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", nm, g, e);
            end
        end
    end

    initial begin
        logic [31:0] p, r;
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; rom_word = 32'h13;
        repeat (2) @(posedge clk);
        #1;

        // sequential NOPs: PC 0,0,4,4,8,8,C ; 3 retired after 6 cycles
        cyc(0, 0, 0, 0, 32'h13, S_F, 32'h0, 32'h13, 0, "reset_state");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'h0, 32'h13, 0, "seq_e0");
        cyc(0, 0, 0, 0, 32'h13, S_F, 32'h4, 32'h13, 1, "seq_f4");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'h4, 32'h13, 1, "seq_e4");
        cyc(0, 0, 0, 0, 32'h13, S_F, 32'h8, 32'h13, 2, "seq_f8");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'h8, 32'h13, 2, "seq_e8");
        // stall: ignored in FETCH, holds EXECUTE three cycles
        cyc(0, 1, 0, 0, 32'h93, S_F, 32'hC, 32'h13, 3, "stall_fetch_ignored");
        cyc(0, 1, 0, 0, 32'h13, S_E, 32'hC, 32'h93, 3, "stall_1");
        cyc(0, 1, 0, 0, 32'h13, S_E, 32'hC, 32'h93, 3, "stall_2");
        cyc(0, 1, 1, 32'h80, 32'h13, S_E, 32'hC, 32'h93, 3, "stall_3_branch_held");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'hC, 32'h93, 3, "stall_release");
        cyc(0, 0, 0, 0, 32'h113, S_F, 32'h10, 32'h93, 4, "after_stall");
        // taken branch to 0x40; branch input in FETCH is ignored
        cyc(0, 0, 1, 32'h40, 32'h13, S_E, 32'h10, 32'h113, 4, "branch_exec");
        cyc(0, 0, 1, 32'h80, 32'h13, S_F, 32'h40, 32'h113, 5, "branch_target");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'h40, 32'h13, 5, "branch_next_e");
        cyc(0, 0, 0, 0, 32'h193, S_F, 32'h44, 32'h13, 6, "pre_misalign");
        // misaligned target 0x42
        cyc(0, 0, 1, 32'h42, 32'h13, S_E, 32'h44, 32'h193, 6, "misalign_exec");
`ifdef FETCH_TRAP_EN
        cyc(0, 0, 1, 32'h42, 32'h13, S_T, 32'h44, 32'h193, 6, "trap_pulse");
        p = 32'h100; r = 6;
`else
        p = 32'h40; r = 7;
`endif
        cyc(0, 0, 0, 0, 32'h13, S_F, p, 32'h193, r, "misalign_fetch");
        // PC wraps from FFFF_FFFC to 0
        cyc(0, 0, 1, 32'hFFFF_FFFC, 32'h13, S_E, p, 32'h13, r, "to_top");
        cyc(0, 0, 0, 0, 32'h13, S_F, 32'hFFFF_FFFC, 32'h13, r + 1, "pc_top");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'hFFFF_FFFC, 32'h13, r + 1, "pc_top_e");
        cyc(0, 0, 0, 0, 32'h0010_0073, S_F, 32'h0, 32'h13, r + 2, "pc_wrap");
        // EBREAK beats a taken branch, then HALT ignores everything
        cyc(0, 0, 1, 32'h80, 32'h13, S_E, 32'h0, 32'h0010_0073, r + 2, "ebreak_exec");
        cyc(0, 0, 1, 32'h200, 32'h13, S_H, 32'h0, 32'h0010_0073, r + 3, "halt_1");
        cyc(0, 1, 1, 32'h204, 32'h13, S_H, 32'h0, 32'h0010_0073, r + 3, "halt_2");
        cyc(1, 0, 1, 32'h208, 32'h13, S_H, 32'h0, 32'h0010_0073, r + 3, "halt_rst_cycle");
        cyc(0, 0, 0, 0, 32'h93, S_F, 32'h0, 32'h13, 0, "halt_cleared");
        // reset in the middle of a stall
        cyc(0, 1, 0, 0, 32'h13, S_E, 32'h0, 32'h93, 0, "midstall_1");
        cyc(1, 1, 1, 32'h40, 32'h13, S_E, 32'h0, 32'h93, 0, "midstall_rst_cycle");
        cyc(0, 0, 0, 0, 32'h13, S_F, 32'h0, 32'h13, 0, "midstall_reset_vals");
        cyc(0, 0, 0, 0, 32'h13, S_E, 32'h0, 32'h13, 0, "post_reset_e");
        cyc(0, 0, 0, 0, 32'h13, S_F, 32'h4, 32'h13, 1, "post_reset_f");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
# fetch_control

Instruction-fetch controller sitting directly upstream of the execute stage. It owns the program counter and the two-phase core state (fetch / execute), drives the fetch address, and latches the instruction word returned during the fetch phase. It also holds that word stable for decode/execute and advances the PC sequentially or to a branch target. It counts retired instructions and halts on EBREAK.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap (only with FETCH_TRAP_EN)

Ports:
- clk_i  in  1  core clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- core_state_o  out  1  0 = INSTRUCTION_FETCH, 1 = INSTRUCTION_EXECUTE
- program_pointer_o  out  32  current PC, used as the bus address during fetch
- program_instr_i  in  32  instruction word from the bus; valid in the fetch cycle only
- instr_o  out  32  latched instruction register (IR) to decode
- instr_valid_o  out  1  high while in EXECUTE
- stall_i  in  1  execute not finished; hold state, PC and IR
- branch_taken_i  in  1  redirect request; sampled in EXECUTE when stall_i = 0
- branch_target_i  in  32  redirect address
- halted_o  out  1  core halted by EBREAK
- trap_o  out  1  one-cycle pulse on misaligned-target trap
- retired_o  out  32  retired-instruction count

## Operation
- States: FETCH, EXECUTE, HALT, TRAP (TRAP exists only with FETCH_TRAP_EN).
- FETCH:
  - core_state_o = 0; program_pointer_o = PC.
  - IR <= program_instr_i at the clock edge.
  - Next state is EXECUTE, unconditionally.
  - stall_i is ignored.
- EXECUTE:
  - core_state_o = 1; instr_valid_o = 1.
  - If stall_i = 1: stay in EXECUTE; hold PC and IR.
  - If stall_i = 0, IR == 32'h0010_0073 (EBREAK): go to HALT; PC unchanged; retired_o + 1.
  - Else if branch_taken_i = 1 and branch_target_i[1:0] != 0 with FETCH_TRAP_EN: go to TRAP; PC unchanged; no retire.
  - Else: PC <= branch_taken_i ? branch_target_i : PC + 4; retired_o + 1; go to FETCH.
- EBREAK takes priority over branch_taken_i.
- TRAP: trap_o = 1 for exactly that cycle; PC <= TRAP_VECTOR; then go to FETCH.
- HALT:
  - core_state_o = 1; instr_valid_o = 0; halted_o = 1.
  - All other inputs are ignored. Only rst_i exits HALT.
- Arithmetic:
  - PC + 4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
  - retired_o wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - state FETCH; PC = RESET_PC; IR = 32'h0000_0013 (NOP).
  - core_state_o 0, instr_valid_o 0, halted_o 0, trap_o 0, retired_o 0.
- rst_i overrides every other input in any state, including a stall in progress or HALT.
- Minimum of 2 cycles per instruction (FETCH + EXECUTE); each stall cycle adds 1.
- The bus read is combinational: program_instr_i is sampled at the end of the FETCH cycle.
- Outputs are registered state/PC/IR. instr_valid_o and core_state_o are decoded from state; there is no combinational path from inputs to outputs.
- The new PC is visible on program_pointer_o in the FETCH cycle that follows EXECUTE.

## Configuration
- Macro: FETCH_TRAP_EN.
- Defined:
  - A misaligned branch target causes the TRAP state and the trap_o pulse.
  - PC is loaded with TRAP_VECTOR.
- Undefined:
  - There is no TRAP state and trap_o is tied to 0.
  - branch_target_i[1:0] is forced to 2'b00 on load, so a misaligned target is silently aligned.

## Structure
- Shared package core_pkg holds:
  - state encodings and the INSTRUCTION_FETCH/INSTRUCTION_EXECUTE constants
  - INSTR_NOP (32'h0000_0013)
  - INSTR_EBREAK (32'h0010_0073)
- Single module; no sub-module needed.

## Test plan
- Reset with RESET_PC = 0, ROM returning NOPs, no stall -> program_pointer_o sequence 0, 0, 4, 4, 8… (one value per cycle); retired_o = 3 after 6 cycles.
- EXECUTE with stall_i high for 3 cycles -> IR, PC and state held; instruction takes 5 cycles total; retired_o increments once.
- branch_taken_i = 1, target 32'h40 in EXECUTE -> next FETCH address is 32'h40; the stale IR does not retire twice.
- IR = EBREAK with branch_taken_i = 1 -> halted_o = 1, PC unchanged, retired_o + 1; a later branch is ignored; rst_i clears HALT.
- With FETCH_TRAP_EN: target 32'h42 -> trap_o pulses for 1 cycle, next fetch at 32'h100, retired_o unchanged. Without the macro: next fetch at 32'h40.
- PC = 32'hFFFF_FFFC, no branch -> next PC is 0; retired_o preloaded near 32'hFFFF_FFFF wraps to 0; rst_i asserted mid-stall -> all reset values on the next cycle.
